// File: rtl/uart_tx_scheduler.sv
// Two-requester UART transmitter: round-robin arbitration, 8E1 framing,
// runtime-configurable clocks-per-bit divisor.
module uart_tx_scheduler #(
   parameter logic [15:0] DEFAULT_DIVISOR = 16'd10,
   parameter logic [2:0]  CFG_OPCODE      = 3'b100
) (
   input  logic        physical_clock,
   input  logic        reset,
   input  logic [2:0]  instruction,
   input  logic [15:0] divisor_value,
   input  logic [1:0]  req,
   input  logic [7:0]  data0,
   input  logic [7:0]  data1,
   output logic [1:0]  grant,
   output logic        tx,
   output logic        busy,
   output logic        frame_done,
   output logic        owner,
   output logic [15:0] divisor,
   output logic        cfg_err
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;

   localparam logic [15:0] MIN_DIVISOR = 16'd2;

   logic [2:0]  state_q, state_d;
   logic [15:0] baud_q, baud_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  shift_q, shift_d;
   logic        parity_q, parity_d;
   logic        tx_q, tx_d;
   logic        busy_q, busy_d;
   logic [1:0]  grant_q, grant_d;
   logic        frame_done_q, frame_done_d;
   logic        cfg_err_q, cfg_err_d;
   logic        owner_q, owner_d;
   logic [15:0] divisor_q, divisor_d;

   logic        cfg_hit;
   logic        bit_end;
   logic        pick;
   logic [7:0]  pick_data;

   always_comb begin
      state_d      = state_q;
      baud_d       = baud_q;
      bit_d        = bit_q;
      shift_d      = shift_q;
      parity_d     = parity_q;
      tx_d         = tx_q;
      owner_d      = owner_q;
      divisor_d    = divisor_q;
      grant_d      = 2'b00;
      frame_done_d = 1'b0;
      cfg_err_d    = 1'b0;

      cfg_hit   = (instruction == CFG_OPCODE);
      bit_end   = (baud_q == divisor_q - 16'd1);
      pick      = (req == 2'b11) ? ~owner_q : req[1];
      pick_data = pick ? data1 : data0;

      if (state_q != S_IDLE) begin
         baud_d = bit_end ? 16'd0 : baud_q + 16'd1;
      end

      case (state_q)
         S_IDLE: begin
            tx_d = 1'b1;
            if (cfg_hit) begin
               divisor_d = (divisor_value < MIN_DIVISOR) ? MIN_DIVISOR : divisor_value;
            end
            if (req != 2'b00) begin
               owner_d  = pick;
               grant_d  = pick ? 2'b10 : 2'b01;
               shift_d  = pick_data;
               parity_d = ^pick_data;
               tx_d     = 1'b0;
               baud_d   = 16'd0;
               bit_d    = 3'd0;
               state_d  = S_START;
            end
         end
         S_START: begin
            if (bit_end) begin
               tx_d    = shift_q[0];
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               if (bit_q == 3'd7) begin
                  tx_d    = parity_q;
                  state_d = S_PARITY;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shift_d = {1'b0, shift_q[7:1]};
                  tx_d    = shift_q[1];
               end
            end
         end
         S_PARITY: begin
            if (bit_end) begin
               tx_d    = 1'b1;
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (bit_end) begin
               tx_d         = 1'b1;
               frame_done_d = 1'b1;
               state_d      = S_IDLE;
            end
         end
         default: begin
            tx_d    = 1'b1;
            state_d = S_IDLE;
         end
      endcase

      // A rejected load in the final stop cycle is dropped silently so that
      // cfg_err never coincides with frame_done.
      if ((state_q != S_IDLE) && cfg_hit && !frame_done_d) begin
         cfg_err_d = 1'b1;
      end

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge physical_clock) begin
      if (reset) begin
         state_q      <= S_IDLE;
         baud_q       <= 16'd0;
         bit_q        <= 3'd0;
         shift_q      <= 8'd0;
         parity_q     <= 1'b0;
         tx_q         <= 1'b1;
         busy_q       <= 1'b0;
         grant_q      <= 2'b00;
         frame_done_q <= 1'b0;
         cfg_err_q    <= 1'b0;
         owner_q      <= 1'b1;
         divisor_q    <= DEFAULT_DIVISOR;
      end else begin
         state_q      <= state_d;
         baud_q       <= baud_d;
         bit_q        <= bit_d;
         shift_q      <= shift_d;
         parity_q     <= parity_d;
         tx_q         <= tx_d;
         busy_q       <= busy_d;
         grant_q      <= grant_d;
         frame_done_q <= frame_done_d;
         cfg_err_q    <= cfg_err_d;
         owner_q      <= owner_d;
         divisor_q    <= divisor_d;
      end
   end

   assign grant      = grant_q;
   assign tx         = tx_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;
   assign owner      = owner_q;
   assign divisor    = divisor_q;
   assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: framing, round-robin, divisor config,
// busy-time config rejection and mid-frame reset.
module tb_uart_tx_scheduler;

   logic        physical_clock = 1'b0;
   logic        reset;
   logic [2:0]  instruction;
   logic [15:0] divisor_value;
   logic [1:0]  req;
   logic [7:0]  data0;
   logic [7:0]  data1;
   logic [1:0]  grant;
   logic        tx;
   logic        busy;
   logic        frame_done;
   logic        owner;
   logic [15:0] divisor;
   logic        cfg_err;

   int checks = 0;
   int errors = 0;

   always #5 physical_clock = ~physical_clock;

   uart_tx_scheduler dut (
      .physical_clock(physical_clock),
      .reset         (reset),
      .instruction   (instruction),
      .divisor_value (divisor_value),
      .req           (req),
      .data0         (data0),
      .data1         (data1),
      .grant         (grant),
      .tx            (tx),
      .busy          (busy),
      .frame_done    (frame_done),
      .owner         (owner),
      .divisor       (divisor),
      .cfg_err       (cfg_err)
   );

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge physical_clock);
      #1;
   endtask

   // Entered one step after the grant edge; leaves at the frame_done cycle.
   // inj >= 0 issues a config load at that clock offset into the frame.
   task automatic run_frame(input logic [7:0] d, input int div, input int inj);
      logic [10:0] pat;
      int k;
      pat = {1'b1, ^d, d, 1'b0};
      for (int b = 0; b < 11; b++) begin
         for (int c = 0; c < div; c++) begin
            k = b * div + c;
            if (c == 0 || c == div - 1) check($sformatf("tx bit%0d c%0d", b, c), 16'(tx), 16'(pat[b]));
            if (c == 0) begin
               check("frame_done low", 16'(frame_done), 16'd0);
               check("busy in frame", 16'(busy), 16'd1);
            end
            if (k == 1) check("grant pulse width", 16'(grant), 16'd0);
            if (k == inj) begin
               check("cfg_err before", 16'(cfg_err), 16'd0);
               instruction   = 3'b100;
               divisor_value = 16'd20;
            end
            if (k == inj + 1 && inj >= 0) begin
               check("cfg_err busy", 16'(cfg_err), 16'd1);
               check("divisor kept", divisor, 16'(div));
               instruction = 3'b000;
            end
            if (k == inj + 2 && inj >= 0) check("cfg_err one cycle", 16'(cfg_err), 16'd0);
            tick();
         end
      end
      check("frame_done", 16'(frame_done), 16'd1);
      check("busy after frame", 16'(busy), 16'd0);
      check("tx idle", 16'(tx), 16'd1);
      check("grant with done", 16'(grant), 16'd0);
      check("cfg_err with done", 16'(cfg_err), 16'd0);
   endtask

   initial begin
      reset = 1'b1; instruction = 3'b000; divisor_value = 16'd0;
      req = 2'b00; data0 = 8'h00; data1 = 8'h00;
      tick(); tick();
      check("rst tx", 16'(tx), 16'd1);
      check("rst busy", 16'(busy), 16'd0);
      check("rst grant", 16'(grant), 16'd0);
      check("rst frame_done", 16'(frame_done), 16'd0);
      check("rst cfg_err", 16'(cfg_err), 16'd0);
      check("rst owner", 16'(owner), 16'd1);
      check("rst divisor", divisor, 16'd10);
      reset = 1'b0;

      // Single frame; req and data changed after grant must not matter.
      req = 2'b01; data0 = 8'hA5;
      tick();
      check("A5 grant", 16'(grant), 16'b01);
      check("A5 owner", 16'(owner), 16'd0);
      req = 2'b00; data0 = 8'hFF;
      run_frame(8'hA5, 10, -1);
      tick();
      check("done pulse width", 16'(frame_done), 16'd0);
      check("idle grant", 16'(grant), 16'd0);

      // Round robin with both requests held.
      reset = 1'b1; tick(); reset = 1'b0;
      req = 2'b11; data0 = 8'h11; data1 = 8'h22;
      tick();
      check("rr grant1", 16'(grant), 16'b01);
      run_frame(8'h11, 10, -1);
      tick();
      check("rr grant2", 16'(grant), 16'b10);
      check("rr gap end", 16'(tx), 16'd0);
      check("rr owner2", 16'(owner), 16'd1);
      run_frame(8'h22, 10, -1);
      tick();
      check("rr grant3", 16'(grant), 16'b01);
      req = 2'b00;
      run_frame(8'h11, 10, -1);
      tick();
      check("rr no grant", 16'(grant), 16'd0);

      // Divisor load in IDLE, parity of 0x07.
      instruction = 3'b100; divisor_value = 16'd4;
      tick();
      instruction = 3'b000;
      check("cfg div4", divisor, 16'd4);
      check("cfg no err", 16'(cfg_err), 16'd0);
      req = 2'b01; data0 = 8'h07;
      tick();
      check("07 grant", 16'(grant), 16'b01);
      req = 2'b00;
      run_frame(8'h07, 4, -1);
      tick();

      // Clamp of divisor 1.
      instruction = 3'b100; divisor_value = 16'd1;
      tick();
      instruction = 3'b000;
      check("cfg clamp", divisor, 16'd2);

      // Load coinciding with arbitration applies to this frame; parity of 0x03.
      instruction = 3'b100; divisor_value = 16'd3; req = 2'b01; data0 = 8'h03;
      tick();
      instruction = 3'b000; req = 2'b00;
      check("03 grant", 16'(grant), 16'b01);
      check("03 divisor", divisor, 16'd3);
      check("03 no err", 16'(cfg_err), 16'd0);
      run_frame(8'h03, 3, -1);
      tick();

      // Config during DATA is rejected, timing unaffected.
      req = 2'b01; data0 = 8'hA5;
      tick();
      req = 2'b00;
      check("A5b grant", 16'(grant), 16'b01);
      run_frame(8'hA5, 3, 10);
      check("div after reject", divisor, 16'd3);
      tick();

      // Reset during data bit 3 aborts the frame.
      req = 2'b01; data0 = 8'hA5;
      tick();
      req = 2'b00;
      repeat (13) tick();
      check("mid busy", 16'(busy), 16'd1);
      reset = 1'b1;
      tick();
      check("abort tx", 16'(tx), 16'd1);
      check("abort busy", 16'(busy), 16'd0);
      check("abort done", 16'(frame_done), 16'd0);
      check("abort owner", 16'(owner), 16'd1);
      check("abort divisor", divisor, 16'd10);
      reset = 1'b0; req = 2'b11;
      tick();
      check("post-rst grant", 16'(grant), 16'b01);
      check("post-rst done", 16'(frame_done), 16'd0);
      req = 2'b00;
      reset = 1'b1;
      tick();
      reset = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
